// File: rtl/rs_age_issue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rs_age_issue
//
// Reservation station for non-load/store uops. It accepts uops from ROB
// dispatch, tracks their two source operands against NWB wakeup buses, and
// presents one ready entry per cycle to the ALU. Dispatch and issue both use
// valid/ready handshakes. A flush clears the whole station.
//
// Build option:
//   RS_OLDEST_FIRST_EN  defined   : an age matrix is kept and the oldest ready
//                                   entry is selected for issue.
//                       undefined : no age matrix; the lowest-index ready entry
//                                   is selected.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   en              global enable; no state change or handshake when low
//   flush           clears every entry at the next edge (independent of en)
//   disp_*          dispatch handshake and payload (op, I/C flag, source tags
//                   and values, destination tag, immediate, PC)
//   wb_valid/tag/data  packed wakeup buses, bus b at [b*W +: W]
//   iss_*           issue handshake and payload of the selected entry
//   count           number of occupied entries
// -----------------------------------------------------------------------------
module rs_age_issue #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 4,
  parameter int DAT_W = 32,
  parameter int OP_W  = 6,
  parameter int ADR_W = 32,
  parameter int NWB   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [OP_W-1:0]        disp_op,
  input  logic                   disp_ic,
  input  logic [TAG_W-1:0]       disp_qj,
  input  logic [TAG_W-1:0]       disp_qk,
  input  logic [DAT_W-1:0]       disp_vj,
  input  logic [DAT_W-1:0]       disp_vk,
  input  logic [TAG_W-1:0]       disp_qd,
  input  logic [DAT_W-1:0]       disp_imm,
  input  logic [ADR_W-1:0]       disp_pc,
  input  logic [NWB-1:0]         wb_valid,
  input  logic [NWB*TAG_W-1:0]   wb_tag,
  input  logic [NWB*DAT_W-1:0]   wb_data,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [OP_W-1:0]        iss_op,
  output logic                   iss_ic,
  output logic [TAG_W-1:0]       iss_qd,
  output logic [DAT_W-1:0]       iss_vs,
  output logic [DAT_W-1:0]       iss_vt,
  output logic [DAT_W-1:0]       iss_imm,
  output logic [ADR_W-1:0]       iss_pc,
  output logic [IDX_W:0]         count
);

  localparam logic [IDX_W:0] LP_DEPTH = (IDX_W+1)'(DEPTH);

  // control state
  logic [DEPTH-1:0]  r_busy;
  logic [IDX_W:0]    r_count;

  // entry payload (no reset: only meaningful while the entry is busy)
  logic [OP_W-1:0]   r_op  [DEPTH];
  logic              r_ic  [DEPTH];
  logic [TAG_W-1:0]  r_qj  [DEPTH];
  logic [TAG_W-1:0]  r_qk  [DEPTH];
  logic [DAT_W-1:0]  r_vj  [DEPTH];
  logic [DAT_W-1:0]  r_vk  [DEPTH];
  logic [TAG_W-1:0]  r_qd  [DEPTH];
  logic [DAT_W-1:0]  r_imm [DEPTH];
  logic [ADR_W-1:0]  r_pc  [DEPTH];

  logic [DEPTH-1:0]  w_ready;
  logic [DEPTH-1:0]  w_sel;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_iss_valid;
  logic              w_disp_fire;
  logic              w_iss_fire;

  logic [TAG_W-1:0]  w_dqj, w_dqk;
  logic [DAT_W-1:0]  w_dvj, w_dvk;
  logic [TAG_W-1:0]  w_nqj [DEPTH];
  logic [TAG_W-1:0]  w_nqk [DEPTH];
  logic [DAT_W-1:0]  w_nvj [DEPTH];
  logic [DAT_W-1:0]  w_nvk [DEPTH];
  logic              w_wb_dup;

  // ---- entry readiness and issue selection ----
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i] = r_busy[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // r_age[i][j] = 1 : entry i is older than entry j
  logic [DEPTH-1:0] r_age [DEPTH];

  // An entry is chosen when no other ready entry is older than it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (w_ready[j] && r_age[j][i]) begin
          w_sel[i] = 1'b0;
        end
      end
    end
  end
`else
  // Isolate the lowest set bit of the ready vector.
  always_comb begin
    w_sel = w_ready & (~w_ready + DEPTH'(1));
  end
`endif

  // w_sel is one-hot (or zero), so OR-ing indices yields the encoded index.
  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel[i]) begin
        w_sel_idx = w_sel_idx | IDX_W'(i);
      end
    end
  end

  // Lowest-index free slot; only used when the station is not full.
  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_iss_valid = |w_ready;
  assign disp_ready  = (r_count < LP_DEPTH);
  assign w_disp_fire = en && !flush && disp_valid && disp_ready;
  assign w_iss_fire  = en && w_iss_valid && iss_ready;

  // ---- wakeup of dispatched and resident operands ----
  // Buses are scanned in ascending order so the highest index wins a tie.
  always_comb begin
    w_dqj = disp_qj;
    w_dvj = disp_vj;
    w_dqk = disp_qk;
    w_dvk = disp_vk;
    for (int b = 0; b < NWB; b++) begin
      if (wb_valid[b] && (wb_tag[b*TAG_W +: TAG_W] != '0)) begin
        if (disp_qj == wb_tag[b*TAG_W +: TAG_W]) begin
          w_dqj = '0;
          w_dvj = wb_data[b*DAT_W +: DAT_W];
        end
        if (disp_qk == wb_tag[b*TAG_W +: TAG_W]) begin
          w_dqk = '0;
          w_dvk = wb_data[b*DAT_W +: DAT_W];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nqj[i] = r_qj[i];
      w_nvj[i] = r_vj[i];
      w_nqk[i] = r_qk[i];
      w_nvk[i] = r_vk[i];
      for (int b = 0; b < NWB; b++) begin
        if (r_busy[i] && wb_valid[b] && (wb_tag[b*TAG_W +: TAG_W] != '0)) begin
          if (r_qj[i] == wb_tag[b*TAG_W +: TAG_W]) begin
            w_nqj[i] = '0;
            w_nvj[i] = wb_data[b*DAT_W +: DAT_W];
          end
          if (r_qk[i] == wb_tag[b*TAG_W +: TAG_W]) begin
            w_nqk[i] = '0;
            w_nvk[i] = wb_data[b*DAT_W +: DAT_W];
          end
        end
      end
    end
  end

  // ---- entry payload update ----
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_disp_fire && (w_free_idx == IDX_W'(i))) begin
          r_op[i]  <= disp_op;
          r_ic[i]  <= disp_ic;
          r_qj[i]  <= w_dqj;
          r_vj[i]  <= w_dvj;
          r_qk[i]  <= w_dqk;
          r_vk[i]  <= w_dvk;
          r_qd[i]  <= disp_qd;
          r_imm[i] <= disp_imm;
          r_pc[i]  <= disp_pc;
        end else begin
          r_qj[i]  <= w_nqj[i];
          r_vj[i]  <= w_nvj[i];
          r_qk[i]  <= w_nqk[i];
          r_vk[i]  <= w_nvk[i];
        end
      end
    end
  end

  // ---- occupancy control ----
  // The free slot is taken from the pre-edge busy vector, so a slot released
  // by this cycle's issue is not reused until the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_busy  <= '0;
      r_count <= '0;
    end else if (en) begin
      if (w_iss_fire) begin
        r_busy[w_sel_idx] <= 1'b0;
      end
      if (w_disp_fire) begin
        r_busy[w_free_idx] <= 1'b1;
      end
      r_count <= r_count + (IDX_W+1)'(w_disp_fire) - (IDX_W+1)'(w_iss_fire);
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // ---- age matrix ----
  // A new entry is younger than everything currently busy: its row is
  // cleared and its column copies the busy vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_age[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_age[i] <= '0;
      end
    end else if (en && w_disp_fire) begin
      r_age[w_free_idx] <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != int'(w_free_idx)) begin
          r_age[j][w_free_idx] <= r_busy[j];
        end
      end
    end
  end
`endif

  // ---- issue outputs ----
  // Payload is forced to zero whenever nothing is presented.
  assign iss_valid = w_iss_valid;
  assign iss_op    = w_iss_valid ? r_op[w_sel_idx]  : '0;
  assign iss_ic    = w_iss_valid ? r_ic[w_sel_idx]  : 1'b0;
  assign iss_qd    = w_iss_valid ? r_qd[w_sel_idx]  : '0;
  assign iss_vs    = w_iss_valid ? r_vj[w_sel_idx]  : '0;
  assign iss_vt    = w_iss_valid ? r_vk[w_sel_idx]  : '0;
  assign iss_imm   = w_iss_valid ? r_imm[w_sel_idx] : '0;
  assign iss_pc    = w_iss_valid ? r_pc[w_sel_idx]  : '0;
  assign count     = r_count;

  // Two active buses carrying the same nonzero tag is an upstream bug.
  always_comb begin
    w_wb_dup = 1'b0;
    for (int b = 0; b < NWB; b++) begin
      for (int c = b + 1; c < NWB; c++) begin
        if (wb_valid[b] && wb_valid[c] && (wb_tag[b*TAG_W +: TAG_W] != '0) &&
            (wb_tag[b*TAG_W +: TAG_W] == wb_tag[c*TAG_W +: TAG_W])) begin
          w_wb_dup = 1'b1;
        end
      end
    end
  end

  a_wb_tag_unique: assert property (@(posedge clk) disable iff (!rst) en |-> !w_wb_dup);

endmodule

// File: tb/tb_rs_age_issue.sv
`timescale 1ns/1ps
module tb_rs_age_issue;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int TAG_W = 4;
  localparam int DAT_W = 32;
  localparam int OP_W  = 6;
  localparam int ADR_W = 32;
  localparam int NWB   = 2;

  logic                 clk = 1'b0;
  logic                 rst, en, flush;
  logic                 disp_valid, disp_ready, disp_ic;
  logic [OP_W-1:0]      disp_op;
  logic [TAG_W-1:0]     disp_qj, disp_qk, disp_qd;
  logic [DAT_W-1:0]     disp_vj, disp_vk, disp_imm;
  logic [ADR_W-1:0]     disp_pc;
  logic [NWB-1:0]       wb_valid;
  logic [NWB*TAG_W-1:0] wb_tag;
  logic [NWB*DAT_W-1:0] wb_data;
  logic                 iss_valid, iss_ready, iss_ic;
  logic [OP_W-1:0]      iss_op;
  logic [TAG_W-1:0]     iss_qd;
  logic [DAT_W-1:0]     iss_vs, iss_vt, iss_imm;
  logic [ADR_W-1:0]     iss_pc;
  logic [IDX_W:0]       count;

  always #5 clk = ~clk;

  rs_age_issue #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W), .DAT_W(DAT_W),
    .OP_W(OP_W), .ADR_W(ADR_W), .NWB(NWB)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_ic(disp_ic), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qd(disp_qd),
    .disp_imm(disp_imm), .disp_pc(disp_pc),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_ic(iss_ic), .iss_qd(iss_qd), .iss_vs(iss_vs), .iss_vt(iss_vt),
    .iss_imm(iss_imm), .iss_pc(iss_pc), .count(count)
  );

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic             ic;
    logic [TAG_W-1:0] qd;
    logic [DAT_W-1:0] vs;
    logic [DAT_W-1:0] vt;
    logic [DAT_W-1:0] imm;
    logic [ADR_W-1:0] pc;
  } pay_t;

  pay_t sb_q[$];
  pay_t mon_act, mon_exp;
  int   errors = 0;
  int   checks = 0;

  // Reference model: a set of slots, each stamped with a dispatch sequence number.
  bit               m_busy [DEPTH];
  logic [OP_W-1:0]  m_op   [DEPTH];
  logic             m_ic   [DEPTH];
  logic [TAG_W-1:0] m_qj   [DEPTH];
  logic [TAG_W-1:0] m_qk   [DEPTH];
  logic [DAT_W-1:0] m_vj   [DEPTH];
  logic [DAT_W-1:0] m_vk   [DEPTH];
  logic [TAG_W-1:0] m_qd   [DEPTH];
  logic [DAT_W-1:0] m_imm  [DEPTH];
  logic [ADR_W-1:0] m_pc   [DEPTH];
  int               m_seq  [DEPTH];
  int               m_stamp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic int m_pick();
    int best = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0) begin
`ifdef RS_OLDEST_FIRST_EN
        if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  function automatic pay_t m_payload(input int s);
    pay_t p;
    p.op = m_op[s]; p.ic = m_ic[s]; p.qd = m_qd[s]; p.vs = m_vj[s];
    p.vt = m_vk[s]; p.imm = m_imm[s]; p.pc = m_pc[s];
    return p;
  endfunction

  task automatic m_wake(inout logic [TAG_W-1:0] q, inout logic [DAT_W-1:0] v);
    for (int b = 0; b < NWB; b++) begin
      if (wb_valid[b] && wb_tag[b*TAG_W +: TAG_W] != 0 && q == wb_tag[b*TAG_W +: TAG_W]) begin
        q = 0;
        v = wb_data[b*DAT_W +: DAT_W];
      end
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
  endtask

  task automatic m_update(input int sel);
    int slot = -1;
    if (!rst || flush) begin
      m_clear();
    end else if (en) begin
      if (disp_valid && m_count() < DEPTH)
        for (int i = 0; i < DEPTH; i++) if (!m_busy[i] && slot < 0) slot = i;
      if (sel >= 0 && iss_ready) m_busy[sel] = 0;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_busy[i]) begin
          m_wake(m_qj[i], m_vj[i]);
          m_wake(m_qk[i], m_vk[i]);
        end
      end
      if (slot >= 0) begin
        m_busy[slot] = 1;
        m_op[slot] = disp_op; m_ic[slot] = disp_ic; m_qd[slot] = disp_qd;
        m_imm[slot] = disp_imm; m_pc[slot] = disp_pc;
        m_qj[slot] = disp_qj; m_vj[slot] = disp_vj;
        m_qk[slot] = disp_qk; m_vk[slot] = disp_vk;
        m_wake(m_qj[slot], m_vj[slot]);
        m_wake(m_qk[slot], m_vk[slot]);
        m_seq[slot] = m_stamp;
        m_stamp++;
      end
    end
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic step();
    int sel = m_pick();
    if (rst && en && sel >= 0 && iss_ready) sb_q.push_back(m_payload(sel));
    @(posedge clk);
    m_update(sel);
    #1;
    chk("count", 64'(count), 64'(m_count()));
    chk("disp_ready", 64'(disp_ready), 64'(m_count() < DEPTH));
    chk("iss_valid", 64'(iss_valid), 64'(m_pick() >= 0));
  endtask

  task automatic idle_inputs();
    flush = 0; disp_valid = 0; wb_valid = '0; wb_tag = '0; wb_data = '0;
  endtask

  task automatic set_disp(input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                          input logic [DAT_W-1:0] vj, input logic [DAT_W-1:0] vk,
                          input logic [TAG_W-1:0] qd);
    disp_valid = 1; disp_qj = qj; disp_qk = qk; disp_vj = vj; disp_vk = vk; disp_qd = qd;
    disp_op = OP_W'($urandom); disp_ic = 1'($urandom);
    disp_imm = $urandom; disp_pc = $urandom;
  endtask

  // Monitor: every completed issue handshake is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst && en && iss_valid && iss_ready) begin
      mon_act = {iss_op, iss_ic, iss_qd, iss_vs, iss_vt, iss_imm, iss_pc};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL issue: got payload %h expected no issue", mon_act);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL issue: got payload %h expected %h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    logic [TAG_W-1:0] t0, t1;
    rst = 0; en = 1; iss_ready = 0;
    idle_inputs();
    set_disp(0, 0, 0, 0, 0);
    disp_valid = 0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_disp_ready", 64'(disp_ready), 1);
    chk("rst_iss_valid", 64'(iss_valid), 0);
    chk("rst_payload", 64'(iss_vs | iss_vt | iss_imm | iss_pc), 0);
    chk("rst_op_qd", 64'({iss_op, iss_ic, iss_qd}), 0);
    rst = 1;

    // Ready-at-dispatch op issues the next cycle.
    iss_ready = 1;
    set_disp(0, 0, 5, 7, 3);
    step();
    disp_valid = 0;
    chk("t1_vs", 64'(iss_vs), 5);
    chk("t1_vt", 64'(iss_vt), 7);
    chk("t1_qd", 64'(iss_qd), 3);
    step();
    chk("t1_count", 64'(count), 0);

    // Wakeup of a waiting source.
    set_disp(2, 0, 0, 9, 6);
    step();
    disp_valid = 0;
    wb_valid = 2'b01; wb_tag = {4'd0, 4'd2}; wb_data = {32'h0, 32'h55};
    iss_ready = 0;
    step();
    wb_valid = '0;
    chk("t2_valid", 64'(iss_valid), 1);
    chk("t2_vs", 64'(iss_vs), 64'h55);
    iss_ready = 1;
    step();

    // Wakeup in the same cycle as dispatch.
    set_disp(0, 4, 1, 0, 7);
    wb_valid = 2'b10; wb_tag = {4'd4, 4'd0}; wb_data = {32'h99, 32'h0};
    iss_ready = 0;
    step();
    idle_inputs();
    chk("t3_valid", 64'(iss_valid), 1);
    chk("t3_vt", 64'(iss_vt), 64'h99);
    iss_ready = 1;
    step();
    step();

    // Fill to full, extra dispatch ignored, then wake and drain in order.
    iss_ready = 0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      set_disp(1, 0, 32'(k), 0, 4'(k));
      step();
    end
    disp_valid = 0;
    chk("full_count", 64'(count), DEPTH);
    chk("full_disp_ready", 64'(disp_ready), 0);
    wb_valid = 2'b01; wb_tag = {4'd0, 4'd1}; wb_data = {32'h0, 32'hA5};
    iss_ready = 1;
    step();
    wb_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      chk("drain_order", 64'(iss_qd), 64'(k));
      step();
    end
    chk("drain_count", 64'(count), 0);

    // Hold under backpressure, then flush with a dispatch in the same cycle.
    iss_ready = 0;
    set_disp(0, 0, 32'h1234, 32'h5678, 9);
    step();
    disp_valid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("hold_vs", 64'(iss_vs), 64'h1234);
      chk("hold_count", 64'(count), 1);
      step();
    end
    flush = 1;
    set_disp(0, 0, 1, 2, 10);
    step();
    idle_inputs();
    chk("flush_valid", 64'(iss_valid), 0);
    chk("flush_count", 64'(count), 0);
    chk("flush_disp_ready", 64'(disp_ready), 1);

    // Asynchronous reset in mid-cycle with four entries busy.
    for (int k = 0; k < 4; k++) begin
      set_disp(1, 0, 32'(k), 0, 4'(k));
      step();
    end
    disp_valid = 0;
    #2 rst = 0;
    #1;
    m_clear();
    chk("arst_count", 64'(count), 0);
    chk("arst_iss_valid", 64'(iss_valid), 0);
    chk("arst_disp_ready", 64'(disp_ready), 1);
    @(posedge clk);
    #1 rst = 1;

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 59) == 0);
      set_disp($urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)),
               $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)),
               $urandom, $urandom, 4'($urandom));
      disp_valid = ($urandom_range(0, 2) != 0);
      iss_ready = ($urandom_range(0, 3) != 0);
      t0 = 4'($urandom_range(1, 15));
      t1 = 4'($urandom_range(1, 15));
      if (t1 == t0) t1 = (t0 % 4'd15) + 4'd1;
      wb_valid = 2'($urandom);
      wb_tag = {t1, t0};
      wb_data = {$urandom, $urandom};
      step();
    end
    idle_inputs();
    en = 1;
    iss_ready = 0;
    step();
    #10;
    chk("scoreboard_empty", 64'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
